fp_frame_serializer: RTL
========================

FP_FRAME_SERIALIZER -- requirements
Module: fp_frame_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: number of 8-bit codes buffered; power of two, 2..16.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  upstream code {s_in,e_in,f_in} is valid this cycle.
REQ-006 in_ready  out  1  block can accept a code this cycle.
REQ-007 s_in  in  1  sign bit from the floating-point converter.
REQ-008 e_in  in  3  exponent from the floating-point converter.
REQ-009 f_in  in  4  mantissa from the floating-point converter.
REQ-010 tx  out  1  serial line; idles high.
REQ-011 busy  out  1  high while a frame is in progress (any state except IDLE).
REQ-012 fifo_count  out  5  number of codes currently buffered, 0..FIFO_DEPTH.

Function
REQ-013 Code word = {s_in,e_in,f_in}; bit 0 = f_in[0], bit 7 = s_in.
REQ-014 Transfer occurs on a cycle with in_valid=1 and in_ready=1; code is written to FIFO tail at that edge.
REQ-015 in_ready = (fifo_count < FIFO_DEPTH), combinational from count only; push is refused when full even if a pop occurs the same cycle.
REQ-016 Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo FIFO_DEPTH.
REQ-017 in_valid while in_ready=0: no write, no state change, no error flag.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: tx=1; if fifo_count>0, pop head into shift register, clear bit timer, go START.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-021 DATA: tx=shift[index], LSB first; each bit held CLKS_PER_BIT cycles; after index 7 go PARITY.
REQ-022 PARITY: tx = XOR of the 8 data bits (even parity), CLKS_PER_BIT cycles, then STOP.
REQ-023 STOP: tx=1 for CLKS_PER_BIT cycles; on last cycle, if fifo_count>0 pop and go directly to START (no idle gap), else go IDLE.
REQ-024 Frame length = 11*CLKS_PER_BIT cycles exactly.
REQ-025 Latency: code accepted at edge N into empty FIFO with FSM in IDLE -> popped at edge N+1 -> tx=0 from edge N+1 onward.
REQ-026 tx and busy are registered (driven from state/shift registers), no combinational path from inputs.
REQ-027 Codes are transmitted in acceptance order; none dropped or duplicated.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, tx=1, busy=0, FIFO pointers=0, fifo_count=0, bit timer and index=0.
REQ-029 After reset in_ready=1; in_valid is ignored on the reset cycle.
REQ-030 Reset mid-frame aborts the frame: tx=1 from the edge after rst sampled high; buffered codes are discarded.
REQ-031 FIFO storage array is not reset; only pointers and count.

Structure
REQ-032 Shared package fp_serial_pkg holds: FSM state enum, CODE_W=8, FRAME_BITS=11, default CLKS_PER_BIT and FIFO_DEPTH.
REQ-033 FIFO is a sub-module fp_code_fifo (push/pop/full/empty/count); FSM, bit timer and shift register live in the top.

Verification
REQ-034 Single code s=0,e=101,f=1010 (0x5A), CLKS_PER_BIT=4 -> tx 0 | 0,1,0,1,1,0,1,0 | parity 0 | 1, each 4 cycles, 44 cycles total, busy high throughout.
REQ-035 Code 0x80 (s=1,e=000,f=0000) -> data bits 0000000 then 1, parity 1.
REQ-036 Push 5 codes back-to-back, FIFO_DEPTH=4 -> in_ready low once count=4 while the first is in flight; all 5 frames emitted in order with no idle cycle between frames.
REQ-037 Push and pop on the same edge with count=2 -> count stays 2, head/tail advance, order preserved across pointer wrap.
REQ-038 Assert rst during DATA bit 3 of a frame with 2 codes queued -> tx=1, busy=0, fifo_count=0 next cycle; no further frames.
REQ-039 Hold in_valid=1 while full for 20 cycles -> no write, count stays 4, no corruption of queued codes.

Source files
------------

// File: rtl/fp_serial_pkg.sv
// Shared types and constants for the floating-point code serializer.
package fp_serial_pkg;
  localparam int CODE_W           = 8;
  localparam int FRAME_BITS       = 11;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int CNT_W            = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ser_state_t;

  function automatic logic even_parity(input logic [CODE_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/fp_frame_serializer_if.sv
// Upstream code handshake: valid/ready plus the sign/exponent/mantissa fields.
interface fp_frame_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic       s_in;
  logic [2:0] e_in;
  logic [3:0] f_in;

  modport master (output in_valid, s_in, e_in, f_in, input in_ready);
  modport slave  (input in_valid, s_in, e_in, f_in, output in_ready);
endinterface

// File: rtl/fp_code_fifo.sv
// Small code FIFO; power-of-two depth so pointers wrap naturally.
module fp_code_fifo
  import fp_serial_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // A full FIFO refuses a push even when a pop frees a slot the same cycle.
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fp_frame_serializer.sv
// Serializes buffered 8-bit FP codes as start/8 data LSB-first/even parity/stop frames.
module fp_frame_serializer
  import fp_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_frame_serializer_if.slave  bus,
  output logic                  tx,
  output logic                  busy,
  output logic [CNT_W-1:0]      fifo_count
);
  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

  ser_state_t        state;
  logic [7:0]        timer;
  logic [2:0]        idx;
  logic [CODE_W-1:0] shift;
  logic [CODE_W-1:0] head;
  logic              full, empty, pop, bit_end;

  assign bit_end     = (timer == BIT_LAST);
  assign bus.in_ready = !full;
  // Pop from IDLE, or on the last stop cycle so back-to-back frames have no gap.
  assign pop = !empty && ((state == ST_IDLE) || (state == ST_STOP && bit_end));

  fp_code_fifo #(.DEPTH(FIFO_DEPTH), .W(CODE_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (pop),
    .din   ({bus.s_in, bus.e_in, bus.f_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      timer <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      timer <= bit_end ? 8'd0 : timer + 8'd1;
      unique case (state)
        ST_IDLE: begin
          timer <= '0;
          if (pop) begin
            shift <= head;
            state <= ST_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            idx   <= '0;
            state <= ST_DATA;
            tx    <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx == 3'd7) begin
              state <= ST_PARITY;
              tx    <= even_parity(shift);
            end else begin
              idx <= idx + 3'd1;
              tx  <= shift[idx + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift <= head;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
